disp_data_ctrl: RTL and testbench
=================================

Name: disp_data_ctrl

Overview:
- Upstream feeder for the 8-digit seven-segment display driver.
- Captures CPU syscall display writes, counts executed cycles until halt, and selects one 32-bit word for display via board switches.
- Generates the slow scan clock on which the display driver advances its digit.
- Sits between the MIPS CPU top level and the display driver. Its outputs connect directly to the driver's clk and data32 inputs.

Parameters:
SCAN_DIV, 50000, clk cycles per scan_clk half-period; legal range 1..2^20-1.
SYNC_STAGES, 2, synchroniser depth for mode and pause switch inputs; legal range 2..3.

Ports:
clk  in  1  system clock
clr  in  1  reset, asynchronous, active-high
halt  in  1  CPU halted (level); stops cycle counter
sys_wr  in  1  one-cycle strobe: CPU syscall display write
sys_data  in  32  value written on sys_wr
pc  in  32  current CPU program counter
mode  in  2  display select switches (asynchronous to clk)
pause  in  1  freeze switch (asynchronous to clk)
scan_clk  out  1  display scan clock, period 2*SCAN_DIV clk
data32  out  32  registered display word
cycle_cnt  out  32  executed-cycle count

Behaviour:
- Reset (clr=1, asynchronous) clears all internal registers: sys_reg, wr_cnt, div_cnt, and the synchronisers.
- Reset outputs: scan_clk=0, data32=0, cycle_cnt=0.
- A reset asserted mid-operation has the same effect, immediately.
- Cycle counter:
  - cycle_cnt+1 on every clk edge while halt=0.
  - Holds while halt=1.
  - Saturates at 0xFFFFFFFF (no wrap).
- Syscall register:
  - sys_reg<=sys_data on any edge with sys_wr=1. This applies regardless of halt, so a write in the same cycle halt rises is kept.
  - wr_cnt (24 bit) increments on each sys_wr, wrapping 0xFFFFFF->0.
- Synchronisers: mode and pause each pass through SYNC_STAGES flops before use (mode_s, pause_s).
- Source select, from mode_s:
  - 0: sys_reg
  - 1: cycle_cnt
  - 2: pc
  - 3: status = {halt, 7'b0, wr_cnt}
- data32 register:
  - Loads the selected source every clk while pause_s=0.
  - Holds its value while pause_s=1.
  - data32 updates one clk after the source changes, and is not affected by pause_s in any other way.
  - Mode-switch latency: SYNC_STAGES+1 clk from the mode pin change to data32 reflecting the new source.
- Scan divider:
  - div_cnt counts 0..SCAN_DIV-1.
  - At div_cnt==SCAN_DIV-1: div_cnt<=0 and scan_clk toggles.
  - SCAN_DIV=1 gives a toggle every clk.
  - scan_clk is a register output (glitch-free) and runs independently of halt and pause.
- Simultaneous events:
  - sys_wr with mode_s=0: data32 shows the new value 2 clk after the strobe edge (sys_reg, then data32).
  - sys_wr with pause_s=1: sys_reg updates, data32 holds.
  - halt rising while mode_s=1: data32 settles to the final count one clk after cycle_cnt stops.

Test Plan:
- Reset: assert clr mid-count with cycle_cnt=0x1234, SCAN_DIV=4 -> immediately cycle_cnt=0, data32=0, scan_clk=0. After release, the first scan_clk rising edge occurs 4 clk later.
- Syscall display: mode=0, pulse sys_wr with sys_data=0xDEADBEEF -> data32=0xDEADBEEF exactly 2 clk later. A second strobe of 0x00000042 -> data32=0x00000042.
- Cycle count and halt: mode=1, halt=0 for 100 clk after reset, then halt=1 -> cycle_cnt stops at 100, data32=100 and stays constant. With mode=3, status[31]=1.
- Saturation: force cycle_cnt near its maximum (preload via hierarchical deposit of 0xFFFFFFFD), halt=0 for 5 clk -> cycle_cnt=0xFFFFFFFF, no wrap to 0.
- Mode latency and pause: SYNC_STAGES=2, change mode 0->2 with pc=0x00400010 -> data32=0x00400010 exactly 3 clk after the change. Then set pause=1 and change pc -> data32 holds 0x00400010. Release pause -> data32 takes the new pc 3 clk later.
- Scan clock: SCAN_DIV=3, run 24 clk -> scan_clk toggles every 3 clk, giving 4 full periods of 6 clk, 50% duty. SCAN_DIV=1 -> toggles every clk.

Source files
------------

// File: rtl/disp_data_ctrl.sv
// rtl/disp_data_ctrl.sv - display data feeder: syscall capture, cycle counter,
// switch-selected display word and scan clock divider.
module disp_data_ctrl #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        halt,
  input  logic        sys_wr,
  input  logic [31:0] sys_data,
  input  logic [31:0] pc,
  input  logic [1:0]  mode,
  input  logic        pause,
  output logic        scan_clk,
  output logic [31:0] data32,
  output logic [31:0] cycle_cnt
);

  localparam int DIV_W = 20;

  logic [SYNC_STAGES-1:0][1:0] mode_sync_q, mode_sync_d;
  logic [SYNC_STAGES-1:0]      pause_sync_q, pause_sync_d;
  logic [31:0]                 cycle_cnt_q, cycle_cnt_d;
  logic [31:0]                 sys_reg_q, sys_reg_d;
  logic [23:0]                 wr_cnt_q, wr_cnt_d;
  logic [31:0]                 data32_q, data32_d;
  logic [DIV_W-1:0]            div_cnt_q, div_cnt_d;
  logic                        scan_clk_q, scan_clk_d;
  logic [1:0]                  mode_s;
  logic                        pause_s;
  logic [31:0]                 sel_word;

  assign mode_s  = mode_sync_q[SYNC_STAGES-1];
  assign pause_s = pause_sync_q[SYNC_STAGES-1];

  always_comb begin
    mode_sync_d  = {mode_sync_q[SYNC_STAGES-2:0], mode};
    pause_sync_d = {pause_sync_q[SYNC_STAGES-2:0], pause};

    // Counter saturates so a very long run never reads back as a short one.
    cycle_cnt_d = cycle_cnt_q;
    if (!halt && (cycle_cnt_q != 32'hFFFF_FFFF)) cycle_cnt_d = cycle_cnt_q + 32'd1;

    sys_reg_d = sys_wr ? sys_data : sys_reg_q;
    wr_cnt_d  = sys_wr ? wr_cnt_q + 24'd1 : wr_cnt_q;

    case (mode_s)
      2'd0:    sel_word = sys_reg_q;
      2'd1:    sel_word = cycle_cnt_q;
      2'd2:    sel_word = pc;
      default: sel_word = {halt, 7'b0, wr_cnt_q};
    endcase
    data32_d = pause_s ? data32_q : sel_word;

    div_cnt_d  = div_cnt_q + DIV_W'(1);
    scan_clk_d = scan_clk_q;
    if (div_cnt_q == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt_d  = '0;
      scan_clk_d = ~scan_clk_q;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mode_sync_q  <= '0;
      pause_sync_q <= '0;
      cycle_cnt_q  <= '0;
      sys_reg_q    <= '0;
      wr_cnt_q     <= '0;
      data32_q     <= '0;
      div_cnt_q    <= '0;
      scan_clk_q   <= 1'b0;
    end else begin
      mode_sync_q  <= mode_sync_d;
      pause_sync_q <= pause_sync_d;
      cycle_cnt_q  <= cycle_cnt_d;
      sys_reg_q    <= sys_reg_d;
      wr_cnt_q     <= wr_cnt_d;
      data32_q     <= data32_d;
      div_cnt_q    <= div_cnt_d;
      scan_clk_q   <= scan_clk_d;
    end
  end

  assign scan_clk  = scan_clk_q;
  assign data32    = data32_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_disp_data_ctrl.sv
// tb/tb_disp_data_ctrl.sv - directed scoreboard bench for disp_data_ctrl.
module tb_disp_data_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        halt = 1'b0;
  logic        sys_wr = 1'b0;
  logic [31:0] sys_data = '0;
  logic [31:0] pc = 32'h0040_0010;
  logic [1:0]  mode = 2'd1;
  logic        pause = 1'b0;
  logic        scan_clk, scan_clk3, scan_clk1;
  logic [31:0] data32, data32_3, data32_1;
  logic [31:0] cycle_cnt, cycle_cnt3, cycle_cnt1;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  disp_data_ctrl #(.SCAN_DIV(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .clr(clr), .halt(halt), .sys_wr(sys_wr), .sys_data(sys_data),
    .pc(pc), .mode(mode), .pause(pause), .scan_clk(scan_clk), .data32(data32),
    .cycle_cnt(cycle_cnt));

  disp_data_ctrl #(.SCAN_DIV(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .clr(clr), .halt(halt), .sys_wr(sys_wr), .sys_data(sys_data),
    .pc(pc), .mode(mode), .pause(pause), .scan_clk(scan_clk3), .data32(data32_3),
    .cycle_cnt(cycle_cnt3));

  disp_data_ctrl #(.SCAN_DIV(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .clr(clr), .halt(halt), .sys_wr(sys_wr), .sys_data(sys_data),
    .pc(pc), .mode(mode), .pause(pause), .scan_clk(scan_clk1), .data32(data32_1),
    .cycle_cnt(cycle_cnt1));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=%h required=expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    int highs;
    int toggles;
    logic prev3;

    // Reset state
    step(2);
    push("rst_cycle_cnt", 32'd0);  chk(cycle_cnt);
    push("rst_data32", 32'd0);     chk(data32);
    push("rst_scan_clk", 32'd0);   chk({31'd0, scan_clk});
    clr = 1'b0;

    // Count to 0x1234, then reset asynchronously mid-cycle
    step(32'h1234);
    push("count_1234", 32'h1234);  chk(cycle_cnt);
    #3 clr = 1'b1;
    #1;
    push("async_cycle_cnt", 32'd0); chk(cycle_cnt);
    push("async_data32", 32'd0);    chk(data32);
    push("async_scan_clk", 32'd0);  chk({31'd0, scan_clk});
    step(1);
    clr = 1'b0;
    step(3);
    push("scan_before_rise", 32'd0); chk({31'd0, scan_clk});
    step(1);
    push("scan_first_rise", 32'd1);  chk({31'd0, scan_clk});

    // Cycle count and halt, mode=1
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(100);
    halt = 1'b1;
    push("halt_cnt", 32'd100);     chk(cycle_cnt);
    step(3);
    push("halt_cnt_hold", 32'd100); chk(cycle_cnt);
    push("halt_data32", 32'd100);   chk(data32);
    step(5);
    push("halt_data32_hold", 32'd100); chk(data32);
    mode = 2'd3;
    step(3);
    push("status_halt", 32'h8000_0000); chk(data32);

    // Syscall display, mode=0
    mode = 2'd0;
    step(3);
    sys_wr = 1'b1;
    sys_data = 32'hDEAD_BEEF;
    step(1);
    sys_wr = 1'b0;
    push("sys_lat1", 32'd0);          chk(data32);
    step(1);
    push("sys_deadbeef", 32'hDEAD_BEEF); chk(data32);
    sys_wr = 1'b1;
    sys_data = 32'h0000_0042;
    step(1);
    sys_wr = 1'b0;
    step(1);
    push("sys_42", 32'h0000_0042);    chk(data32);
    mode = 2'd3;
    step(3);
    push("status_wrcnt", 32'h8000_0002); chk(data32);

    // Mode latency and pause
    mode = 2'd0;
    step(3);
    mode = 2'd2;
    step(2);
    push("mode_lat2", 32'h0000_0042); chk(data32);
    step(1);
    push("mode_lat3", 32'h0040_0010); chk(data32);
    pause = 1'b1;
    step(3);
    pc = 32'h0040_0020;
    step(4);
    push("pause_hold", 32'h0040_0010); chk(data32);
    sys_wr = 1'b1;
    sys_data = 32'h1111_2222;
    step(1);
    sys_wr = 1'b0;
    step(2);
    push("pause_sys_hold", 32'h0040_0010); chk(data32);
    pause = 1'b0;
    step(2);
    push("unpause_lat2", 32'h0040_0010); chk(data32);
    step(1);
    push("unpause_lat3", 32'h0040_0020); chk(data32);
    mode = 2'd0;
    step(3);
    push("pause_sys_kept", 32'h1111_2222); chk(data32);

    // Saturation
    dut.cycle_cnt_q = 32'hFFFF_FFFD;
    halt = 1'b0;
    step(1);
    push("sat_step1", 32'hFFFF_FFFE); chk(cycle_cnt);
    step(4);
    push("sat_max", 32'hFFFF_FFFF);   chk(cycle_cnt);

    // Scan clock with SCAN_DIV=3 and SCAN_DIV=1
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    highs = 0;
    toggles = 0;
    prev3 = scan_clk3;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      push("scan3", 32'((k / 3) % 2)); chk({31'd0, scan_clk3});
      push("scan1", 32'(k % 2));       chk({31'd0, scan_clk1});
      if (scan_clk3) highs++;
      if (scan_clk3 !== prev3) toggles++;
      prev3 = scan_clk3;
    end
    push("scan3_highs", 32'd12);  chk(32'(highs));
    push("scan3_toggles", 32'd8); chk(32'(toggles));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
